// File: rtl/cdbus_rx_deframer_pkg.sv
// Shared CDBUS definitions: CRC constants, addressing, header layout and
// the receive deframer state encoding.
package cdbus_pkg;

    localparam logic [15:0] CRC_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC_POLY   = 16'hA001;
    localparam logic [7:0]  BCAST_ADDR = 8'hFF;

    // Byte counter is 9 bits wide so that len + 4 (up to 257) fits.
    localparam int unsigned CNT_W = 32'd9;

    localparam logic [8:0] HDR_SRC  = 9'd0;
    localparam logic [8:0] HDR_DST  = 9'd1;
    localparam logic [8:0] HDR_LEN  = 9'd2;
    localparam logic [8:0] HDR_SIZE = 9'd3;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_RECV      = 2'd2,
        ST_CHECK     = 2'd3
    } rx_state_e;

    // A frame is for us if it names us, is broadcast, or we listen to everything.
    function automatic logic dst_accept(input logic [7:0] dst,
                                        input logic [7:0] local_addr,
                                        input logic       promisc);
        return (dst == local_addr) || (dst == BCAST_ADDR) || promisc;
    endfunction

endpackage

// File: rtl/cdbus_rx_deframer_if.sv
// Byte-stream, buffer-write and status bundle of the CDBUS receive deframer.
// master = UART/host side, slave = deframer.
interface cdbus_rx_deframer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              idle_i;
    logic [7:0]        local_addr_i;
    logic              promisc_i;
    logic              buf_free_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;
    logic              frame_done_o;
    logic [7:0]        frame_len_o;
    logic              crc_err_o;
    logic              len_err_o;
    logic              ovf_o;

    modport master (
        output byte_i, byte_valid_i, idle_i, local_addr_i, promisc_i, buf_free_i,
        input  wr_en_o, wr_addr_o, wr_data_o, frame_done_o, frame_len_o,
               crc_err_o, len_err_o, ovf_o
    );

    modport slave (
        input  byte_i, byte_valid_i, idle_i, local_addr_i, promisc_i, buf_free_i,
        output wr_en_o, wr_addr_o, wr_data_o, frame_done_o, frame_len_o,
               crc_err_o, len_err_o, ovf_o
    );
endinterface

// File: rtl/cdbus_crc16_byte.sv
// Combinational CRC16/Modbus update by one byte (reflected, LSB first).
// Shared between the receive deframer and the transmit framer.
module cdbus_crc16_byte
    import cdbus_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_s;

    // Fold the byte in, then eight reflected shift/xor steps.
    always_comb begin
        crc_s = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (crc_s[0]) begin
                crc_s = {1'b0, crc_s[15:1]} ^ CRC_POLY;
            end else begin
                crc_s = {1'b0, crc_s[15:1]};
            end
        end
        crc_out = crc_s;
    end

endmodule

// File: rtl/cdbus_rx_deframer.sv
// CDBUS receive deframer: assembles src/dst/len/data/crc frames from the
// UART byte stream, filters on destination, checks CRC16/Modbus, writes the
// frame into the RX buffer and reports one status pulse per frame.
module cdbus_rx_deframer
    import cdbus_pkg::*;
#(
    parameter int unsigned MAX_DATA = 253,
    parameter int unsigned ADDR_W   = 8
)(
    input  logic               clk_i,
    input  logic               rst_i,
    cdbus_rx_deframer_if.slave bus
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_DATA);

    rx_state_e         state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [7:0]        len_r, len_s;
    logic [15:0]       crc_r, crc_s;
    logic [15:0]       crc_in_s, crc_upd_s;
    logic              start_s;

    logic              wr_en_r, wr_en_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [7:0]        wr_data_r, wr_data_s;
    logic              done_r, done_s;
    logic [7:0]        frame_len_r, frame_len_s;
    logic              crc_err_r, crc_err_s;
    logic              len_err_r, len_err_s;
    logic              ovf_r, ovf_s;

    // An idle gap is handled before any byte of the same cycle, so the
    // deframer is effectively in IDLE whenever idle_i is high.
    assign start_s = (state_r == ST_IDLE) || bus.idle_i;

    // A frame-start byte folds into a fresh CRC, every later byte into the running one.
    always_comb begin
        if (start_s) begin
            crc_in_s = CRC_INIT;
        end else begin
            crc_in_s = crc_r;
        end
    end

    cdbus_crc16_byte u_crc (
        .crc_in  (crc_in_s),
        .data_in (bus.byte_i),
        .crc_out (crc_upd_s)
    );

    // Next-state, counter, CRC, buffer-write and status decode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        len_s       = len_r;
        crc_s       = crc_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        done_s      = 1'b0;
        frame_len_s = frame_len_r;
        crc_err_s   = 1'b0;
        len_err_s   = 1'b0;
        ovf_s       = 1'b0;

        // Verdict on the frame whose last CRC byte arrived last cycle.
        if (state_r == ST_CHECK) begin
            if (crc_r == 16'h0000) begin
                done_s      = 1'b1;
                frame_len_s = len_r;
            end else begin
                crc_err_s = 1'b1;
            end
        end else begin
            done_s = 1'b0;
        end

        // An idle gap inside a frame means it was cut short.
        if ((state_r == ST_RECV) && bus.idle_i) begin
            len_err_s = 1'b1;
        end else begin
            len_err_s = 1'b0;
        end

        if (start_s) begin
            if (bus.byte_valid_i) begin
                if (bus.buf_free_i) begin
                    state_s   = ST_RECV;
                    cnt_s     = HDR_SRC + 9'd1;
                    crc_s     = crc_upd_s;
                    wr_en_s   = 1'b1;
                    wr_addr_s = ADDR_W'(HDR_SRC);
                    wr_data_s = bus.byte_i;
                end else begin
                    ovf_s   = 1'b1;
                    state_s = ST_WAIT_IDLE;
                    crc_s   = CRC_INIT;
                    cnt_s   = 9'd0;
                end
            end else begin
                state_s = ST_IDLE;
                crc_s   = CRC_INIT;
                cnt_s   = 9'd0;
            end
        end else begin
            case (state_r)
                ST_RECV: begin
                    if (bus.byte_valid_i) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = ADDR_W'(cnt_r);
                        wr_data_s = bus.byte_i;
                        cnt_s     = cnt_r + 9'd1;
                        crc_s     = crc_upd_s;
                        if (cnt_r == HDR_DST) begin
                            if (!dst_accept(bus.byte_i, bus.local_addr_i, bus.promisc_i)) begin
                                state_s = ST_WAIT_IDLE;
                            end else begin
                                state_s = ST_RECV;
                            end
                        end else if (cnt_r == HDR_LEN) begin
                            len_s = bus.byte_i;
                            if (bus.byte_i > MAX_LEN) begin
                                len_err_s = 1'b1;
                                state_s   = ST_WAIT_IDLE;
                            end else begin
                                state_s = ST_RECV;
                            end
                        end else if ((cnt_r >= HDR_SIZE) && (cnt_r == ({1'b0, len_r} + 9'd4))) begin
                            state_s = ST_CHECK;
                        end else begin
                            state_s = ST_RECV;
                        end
                    end else begin
                        state_s = ST_RECV;
                    end
                end
                ST_CHECK: begin
                    state_s = ST_WAIT_IDLE;
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_WAIT_IDLE;
            cnt_r       <= 9'd0;
            len_r       <= 8'h00;
            crc_r       <= CRC_INIT;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 8'h00;
            done_r      <= 1'b0;
            frame_len_r <= 8'h00;
            crc_err_r   <= 1'b0;
            len_err_r   <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            len_r       <= len_s;
            crc_r       <= crc_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            done_r      <= done_s;
            frame_len_r <= frame_len_s;
            crc_err_r   <= crc_err_s;
            len_err_r   <= len_err_s;
            ovf_r       <= ovf_s;
        end
    end

    assign bus.wr_en_o      = wr_en_r;
    assign bus.wr_addr_o    = wr_addr_r;
    assign bus.wr_data_o    = wr_data_r;
    assign bus.frame_done_o = done_r;
    assign bus.frame_len_o  = frame_len_r;
    assign bus.crc_err_o    = crc_err_r;
    assign bus.len_err_o    = len_err_r;
    assign bus.ovf_o        = ovf_r;

endmodule

// File: tb/tb_cdbus_rx_deframer.sv
// Scoreboard bench for the CDBUS receive deframer.
module tb_cdbus_rx_deframer;

    localparam int K_DONE = 0;
    localparam int K_CRC  = 1;
    localparam int K_LEN  = 2;
    localparam int K_OVF  = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] len;
    } sts_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cycle_cnt = 0;

    logic [15:0] wr_q[$];
    sts_t        sts_q[$];
    logic [7:0]  frame_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    cdbus_rx_deframer_if #(.ADDR_W(8)) bus ();

    cdbus_rx_deframer #(.MAX_DATA(253), .ADDR_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Output monitor: every write and every status pulse is popped against the scoreboard.
    always @(negedge clk) begin : mon
        logic [15:0] w;
        logic [3:0]  p;
        sts_t        s;
        if (bus.wr_en_o === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %0d data %02h, required no write",
                         bus.wr_addr_o, bus.wr_data_o);
            end else begin
                w = wr_q.pop_front();
                if ({bus.wr_addr_o, bus.wr_data_o} !== w) begin
                    errors++;
                    $display("FAIL write_value: got addr %0d data %02h, required addr %0d data %02h",
                             bus.wr_addr_o, bus.wr_data_o, w[15:8], w[7:0]);
                end
            end
        end
        p = {bus.ovf_o, bus.len_err_o, bus.crc_err_o, bus.frame_done_o};
        for (int k = 0; k < 4; k++) begin
            if (p[k] !== 1'b0) begin
                checks++;
                if (sts_q.size() == 0) begin
                    errors++;
                    $display("FAIL status_unexpected: got pulse kind %0d at cycle %0d, required none",
                             k, cycle_cnt);
                end else begin
                    s = sts_q.pop_front();
                    if ((s.kind != k) || (s.cyc != cycle_cnt) ||
                        ((k == K_DONE) && (bus.frame_len_o !== s.len))) begin
                        errors++;
                        $display("FAIL status_value: got kind %0d cycle %0d len %0d, required kind %0d cycle %0d len %0d",
                                 k, cycle_cnt, bus.frame_len_o, s.kind, s.cyc, s.len);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] crc_of_frame();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (frame_q[i]) begin
            c = c ^ {8'h00, frame_q[i]};
            for (int b = 0; b < 8; b++) begin
                if (c[0]) c = (c >> 1) ^ 16'hA001;
                else      c = c >> 1;
            end
        end
        return c;
    endfunction

    // One clock of stimulus, entered and left at posedge+1.
    task automatic drive(input logic v, input logic [7:0] b, input logic idl);
        bus.byte_valid_i = v;
        bus.byte_i       = b;
        bus.idle_i       = idl;
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
        bus.idle_i       = 1'b0;
    endtask

    task automatic build_frame(input logic [7:0] src, input logic [7:0] dst,
                               input logic [7:0] len, input logic [7:0] seed,
                               input logic [7:0] crc_hi_flip);
        logic [15:0] c;
        frame_q.delete();
        frame_q.push_back(src);
        frame_q.push_back(dst);
        frame_q.push_back(len);
        for (int i = 0; i < int'(len); i++) frame_q.push_back(seed + 8'(i));
        c = crc_of_frame();
        frame_q.push_back(c[7:0]);
        frame_q.push_back(c[15:8] ^ crc_hi_flip);
    endtask

    // Send the first n_send bytes of frame_q (all if negative); expect n_wr writes
    // and optionally one status pulse triggered by byte st_idx.
    task automatic send_frame(input int n_send, input int n_wr, input int kind,
                              input int st_idx, input logic [7:0] st_len,
                              input logic first_idle, input int drop_free_at);
        sts_t s;
        int   n;
        n = (n_send < 0) ? frame_q.size() : n_send;
        for (int i = 0; i < n; i++) begin
            if (i < n_wr) wr_q.push_back({8'(i), frame_q[i]});
            if ((kind >= 0) && (i == st_idx)) begin
                s.kind = kind;
                s.cyc  = cycle_cnt + (((kind == K_DONE) || (kind == K_CRC)) ? 2 : 1);
                s.len  = st_len;
                sts_q.push_back(s);
            end
            if (i == drop_free_at) bus.buf_free_i = 1'b0;
            drive(1'b1, frame_q[i], first_idle && (i == 0));
        end
    endtask

    task automatic idle_pulse(input logic expect_len_err);
        sts_t s;
        if (expect_len_err) begin
            s.kind = K_LEN;
            s.cyc  = cycle_cnt + 1;
            s.len  = 8'h00;
            sts_q.push_back(s);
        end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic settle();
        repeat (4) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.wr_en_o, bus.frame_done_o, bus.crc_err_o, bus.len_err_o, bus.ovf_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %05b, required 00000",
                     {bus.wr_en_o, bus.frame_done_o, bus.crc_err_o, bus.len_err_o, bus.ovf_o});
        end
        checks++;
        if ({bus.wr_addr_o, bus.wr_data_o, bus.frame_len_o} !== 24'h0) begin
            errors++;
            $display("FAIL reset_values: got addr %0d data %02h len %0d, required 0 0 0",
                     bus.wr_addr_o, bus.wr_data_o, bus.frame_len_o);
        end
        rst = 1'b0;
        // No idle yet: a well-formed frame must be ignored.
        build_frame(8'h00, 8'h01, 8'd1, 8'hCD, 8'h00);
        send_frame(-1, 0, -1, 0, 8'h00, 1'b0, -1);
        settle();
        checks++;
        if (wr_q.size() + sts_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_idle: pending %0d, required 0", wr_q.size() + sts_q.size());
            wr_q.delete(); sts_q.delete();
        end
    endtask

    task automatic test_good_and_crc();
        idle_pulse(1'b0);
        build_frame(8'h00, 8'h01, 8'd1, 8'hCD, 8'h00);
        send_frame(-1, 6, K_DONE, 5, 8'd1, 1'b0, -1);
        settle();
        idle_pulse(1'b0);
        build_frame(8'h00, 8'h01, 8'd1, 8'hCD, 8'h01);
        send_frame(-1, 6, K_CRC, 5, 8'd0, 1'b0, -1);
        settle();
        checks++;
        if (bus.frame_len_o !== 8'd1) begin
            errors++;
            $display("FAIL frame_len_hold: got %0d, required 1", bus.frame_len_o);
        end
        checks++;
        if (wr_q.size() + sts_q.size() != 0) begin
            errors++;
            $display("FAIL good_crc_pending: pending %0d, required 0", wr_q.size() + sts_q.size());
            wr_q.delete(); sts_q.delete();
        end
    endtask

    task automatic test_addr_filter();
        idle_pulse(1'b0);
        build_frame(8'h00, 8'h05, 8'd1, 8'hCD, 8'h00);
        send_frame(-1, 2, -1, 0, 8'h00, 1'b0, -1);
        settle();
        bus.promisc_i = 1'b1;
        idle_pulse(1'b0);
        send_frame(-1, 6, K_DONE, 5, 8'd1, 1'b0, -1);
        settle();
        bus.promisc_i = 1'b0;
        idle_pulse(1'b0);
        build_frame(8'h03, 8'hFF, 8'd2, 8'h10, 8'h00);
        send_frame(-1, 7, K_DONE, 6, 8'd2, 1'b0, -1);
        settle();
        checks++;
        if (wr_q.size() + sts_q.size() != 0) begin
            errors++;
            $display("FAIL addr_filter_pending: pending %0d, required 0", wr_q.size() + sts_q.size());
            wr_q.delete(); sts_q.delete();
        end
    endtask

    task automatic test_len_errors();
        idle_pulse(1'b0);
        frame_q = '{8'h00, 8'h01, 8'hFE, 8'h11, 8'h22};
        send_frame(-1, 3, K_LEN, 2, 8'h00, 1'b0, -1);
        settle();
        idle_pulse(1'b0);
        build_frame(8'h00, 8'h01, 8'd3, 8'h40, 8'h00);
        send_frame(4, 4, -1, 0, 8'h00, 1'b0, -1);
        idle_pulse(1'b1);
        // Truncation leaves the deframer in IDLE: next frame needs no extra idle.
        send_frame(-1, 8, K_DONE, 7, 8'd3, 1'b0, -1);
        settle();
        idle_pulse(1'b0);
        build_frame(8'h02, 8'h01, 8'd0, 8'h00, 8'h00);
        send_frame(-1, 5, K_DONE, 4, 8'd0, 1'b0, -1);
        settle();
        checks++;
        if (wr_q.size() + sts_q.size() != 0) begin
            errors++;
            $display("FAIL len_err_pending: pending %0d, required 0", wr_q.size() + sts_q.size());
            wr_q.delete(); sts_q.delete();
        end
    endtask

    task automatic test_ovf();
        idle_pulse(1'b0);
        build_frame(8'h00, 8'h01, 8'd1, 8'hCD, 8'h00);
        bus.buf_free_i = 1'b0;
        send_frame(-1, 0, K_OVF, 0, 8'h00, 1'b0, -1);
        settle();
        bus.buf_free_i = 1'b1;
        idle_pulse(1'b0);
        // Dropping buf_free mid-frame must not matter.
        send_frame(-1, 6, K_DONE, 5, 8'd1, 1'b0, 3);
        bus.buf_free_i = 1'b1;
        settle();
        checks++;
        if (wr_q.size() + sts_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_pending: pending %0d, required 0", wr_q.size() + sts_q.size());
            wr_q.delete(); sts_q.delete();
        end
    endtask

    task automatic test_rst_mid();
        idle_pulse(1'b0);
        build_frame(8'h00, 8'h01, 8'd1, 8'hCD, 8'h00);
        send_frame(3, 3, -1, 0, 8'h00, 1'b0, -1);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        send_frame(-1, 0, -1, 0, 8'h00, 1'b0, -1);
        settle();
        idle_pulse(1'b0);
        send_frame(-1, 6, K_DONE, 5, 8'd1, 1'b0, -1);
        settle();
        checks++;
        if (wr_q.size() + sts_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_pending: pending %0d, required 0", wr_q.size() + sts_q.size());
            wr_q.delete(); sts_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        idle_pulse(1'b0);
        build_frame(8'h07, 8'h01, 8'd2, 8'hA0, 8'h00);
        send_frame(-1, 7, K_DONE, 6, 8'd2, 1'b0, -1);
        frame_q = '{8'hAA, 8'hBB};
        send_frame(-1, 0, -1, 0, 8'h00, 1'b0, -1);
        // Idle and first byte in the same cycle start a frame.
        build_frame(8'h08, 8'h01, 8'd1, 8'h5A, 8'h00);
        send_frame(-1, 6, K_DONE, 5, 8'd1, 1'b1, -1);
        settle();
        checks++;
        if (wr_q.size() + sts_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_pending: pending %0d, required 0", wr_q.size() + sts_q.size());
            wr_q.delete(); sts_q.delete();
        end
    endtask

    initial begin
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        bus.idle_i       = 1'b0;
        bus.local_addr_i = 8'h01;
        bus.promisc_i    = 1'b0;
        bus.buf_free_i   = 1'b1;
        test_reset();
        test_good_and_crc();
        test_addr_filter();
        test_len_errors();
        test_ovf();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdbus_rx_deframer.md
Name: cdbus_rx_deframer

Overview:
Receive-side frame stage of the CDBUS RS485 node. It sits directly downstream of the UART byte receiver and upstream of the packet RAM and host logic.
- Assembles bytes into frames of the form src, dst, len, data[len], crc_lo, crc_hi.
- Applies an address filter, checks CRC16/Modbus, and writes accepted frames into the RX buffer.
- Reports completion or error per frame.

Parameters:
MAX_DATA, 253, largest legal len byte; a larger len drops the frame.
ADDR_W, 8, width of the buffer write address.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
byte_i  in  8  received byte from UART receiver
byte_valid_i  in  1  one-cycle strobe, byte_i valid
idle_i  in  1  one-cycle pulse, bus idle gap detected by receiver
local_addr_i  in  8  this node's address
promisc_i  in  1  accept any dst
buf_free_i  in  1  consumer has an empty buffer
wr_en_o  out  1  buffer write strobe
wr_addr_o  out  ADDR_W  buffer byte index (0 = src)
wr_data_o  out  8  buffer write data
frame_done_o  out  1  pulse, good frame in buffer
frame_len_o  out  8  len byte of last good frame, held until next done
crc_err_o  out  1  pulse, CRC residue nonzero
len_err_o  out  1  pulse, len > MAX_DATA or frame truncated by idle
ovf_o  out  1  pulse, frame start while buf_free_i low

Behaviour:
- Reset: all outputs 0, state WAIT_IDLE, counters 0, CRC register 0xFFFF.
- States and transitions:
  - WAIT_IDLE: ignore bytes; idle_i -> IDLE.
  - IDLE: on byte_valid_i:
    - buf_free_i=1 -> RECV, write byte at index 0.
    - buf_free_i=0 -> pulse ovf_o, go to WAIT_IDLE.
  - RECV: each byte_valid_i writes at index cnt, then cnt+1.
    - Index 1 (dst): if dst!=local_addr_i, dst!=0xFF and promisc_i=0 -> WAIT_IDLE silently. Byte 1 is still written; harmless.
    - Index 2 (len): if len>MAX_DATA -> pulse len_err_o, WAIT_IDLE.
    - When cnt reaches len+4 (final CRC byte) -> CHECK.
  - CHECK (one cycle):
    - CRC register == 0x0000 -> frame_done_o=1, frame_len_o=len.
    - Otherwise crc_err_o=1.
    - Then WAIT_IDLE.
- CRC:
  - CRC16/Modbus, reflected poly 0xA001, init 0xFFFF.
  - Updated over every byte including both CRC bytes; a good frame leaves residue 0.
  - Reinitialised to 0xFFFF on entry to IDLE.
- Write path latency: wr_en_o/wr_addr_o/wr_data_o are registered and appear the cycle after byte_valid_i. wr_addr_o is zero-extended cnt.
- Status latency: the last byte's strobe is cycle N. Its write occurs at N+1, and frame_done_o or crc_err_o at N+2.
- All status pulses are exactly one cycle and mutually exclusive per frame.
- Boundaries:
  - idle_i in RECV: truncated frame; pulse len_err_o, go to IDLE (not WAIT_IDLE).
  - idle_i and byte_valid_i in the same cycle: idle_i is processed first, then the byte is treated as a frame start in IDLE.
  - len=0: a 5-byte frame is legal.
  - Bytes after a completed frame before idle: ignored, no pulse.
  - buf_free_i is sampled only at frame start; deassertion mid-frame has no effect.
  - rst_i mid-frame: frame abandoned, no pulses, state returns to WAIT_IDLE.
  - After reset, a frame is not accepted until the first idle_i.

Decomposition:
- Shared package cdbus_pkg holds:
  - CRC constants CRC_INIT=16'hFFFF and CRC_POLY=16'hA001.
  - BCAST_ADDR=8'hFF.
  - Header offsets HDR_SRC=0, HDR_DST=1, HDR_LEN=2, HDR_SIZE=3.
  - State encoding.
- Sub-module cdbus_crc16_byte: combinational one-byte CRC update (crc_in, byte -> crc_out, 8 unrolled shift steps). It is reused by the TX framer.

Test Plan:
- Reset, idle_i, then frame 00 01 01 CD + correct CRC with local_addr_i=0x01 -> 6 writes at addr 0..5. frame_done_o at N+2 with frame_len_o=1; no other pulses.
- Same frame with the CRC high byte XOR 0x01 -> crc_err_o pulse, no frame_done_o.
- dst=0x05, local_addr_i=0x01, promisc_i=0 -> no pulses, no writes past addr 1. Repeat with promisc_i=1, and with dst=0xFF -> frame_done_o.
- len=0xFE with MAX_DATA=253 -> len_err_o at byte index 2. Separately, idle_i after 4 bytes of a len=3 frame -> len_err_o; the next good frame is accepted.
- buf_free_i=0 at the first byte -> ovf_o, no writes. After idle_i, a frame with buf_free_i=1 -> frame_done_o.
- Assert rst_i at byte 3 of a frame, then send a good frame without an idle_i -> ignored. After idle_i, a good frame -> frame_done_o.
